// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus level constants, byte width.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRx,
    StRxAck,
    StTx,
    StTxAck,
    StIgnore
  } tgt_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an I2C line with a history flop for edge pulses.
// All flops reset to 1 (idle bus level).
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_prev,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_last <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_last <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_prev  = r_last;
  assign o_rise  = r_sync & ~r_last;
  assign o_fall  = ~r_sync & r_last;

endmodule

// File: rtl/i2c_target.sv
// I2C target responder: fixed-address match, write receive, read transmit.
// Optional clock stretching on read data is enabled by I2C_TARGET_CLK_STRETCH_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = BYTE_W,
  parameter int unsigned           ADDR_WIDTH  = 7,
  parameter logic [ADDR_WIDTH-1:0] DEVICE_ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic                  scl_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_req,
  output logic                  rw,
  busy,
  output logic                  start_det,
  output logic                  stop_det
);

  localparam logic [3:0] LastBit = 4'(DATA_WIDTH);

  logic w_scl_level, w_scl_prev, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_prev, w_sda_rise, w_sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .i_line (scl_i),
    .o_level(w_scl_level),
    .o_prev (w_scl_prev),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .i_line (sda_i),
    .o_level(w_sda_level),
    .o_prev (w_sda_prev),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  // SDA edges are classified against the SCL level from before any coincident SCL edge.
  logic w_start, w_stop;
  assign w_start = w_sda_fall & (w_scl_prev == HIGH);
  assign w_stop  = w_sda_rise & (w_scl_prev == HIGH);

  logic w_tx_ok;
`ifdef I2C_TARGET_CLK_STRETCH_EN
  assign w_tx_ok = tx_valid;
`else
  assign w_tx_ok = 1'b1;
`endif

  tgt_state_e            r_state, w_state_d;
  logic [3:0]            r_cnt, w_cnt_d;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_d;
  logic r_sda_oe, w_sda_oe_d, r_scl_oe, w_scl_oe_d, r_rw, w_rw_d, r_busy, w_busy_d;
  logic r_ack, w_ack_d, r_stretch, w_stretch_d;
  logic r_rx_valid, w_rx_valid_d, r_tx_req, w_tx_req_d;
  logic r_start_det, w_start_det_d, r_stop_det, w_stop_det_d;
  logic w_load_req, w_match;

  assign w_match = (r_shift[DATA_WIDTH-1 -: ADDR_WIDTH] == DEVICE_ADDR) &&
                   (r_shift[DATA_WIDTH-1 -: ADDR_WIDTH] != '0);

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_shift_d     = r_shift;
    w_rx_data_d   = r_rx_data;
    w_sda_oe_d    = r_sda_oe;
    w_scl_oe_d    = 1'b0;
    w_rw_d        = r_rw;
    w_busy_d      = r_busy;
    w_ack_d       = r_ack;
    w_stretch_d   = r_stretch;
    w_rx_valid_d  = 1'b0;
    w_tx_req_d    = 1'b0;
    w_start_det_d = 1'b0;
    w_stop_det_d  = 1'b0;
    w_load_req    = 1'b0;

    if (w_stop) begin
      w_state_d    = StIdle;
      w_sda_oe_d   = 1'b0;
      w_busy_d     = 1'b0;
      w_stretch_d  = 1'b0;
      w_stop_det_d = 1'b1;
    end else if (w_start) begin
      w_state_d     = StAddr;
      w_cnt_d       = '0;
      w_sda_oe_d    = 1'b0;
      w_stretch_d   = 1'b0;
      w_start_det_d = 1'b1;
    end else begin
      unique case (r_state)
        StAddr, StRx: begin
          if (w_scl_rise) begin
            w_shift_d = {r_shift[DATA_WIDTH-2:0], w_sda_level};
            w_cnt_d   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == LastBit) begin
            if (r_state == StRx) begin
              w_rx_data_d  = r_shift;
              w_rx_valid_d = 1'b1;
              w_sda_oe_d   = 1'b1;
              w_state_d    = StRxAck;
            end else if (w_match) begin
              w_sda_oe_d = 1'b1;
              w_rw_d     = r_shift[0];
              w_busy_d   = 1'b1;
              w_state_d  = StAddrAck;
            end else begin
              w_busy_d  = 1'b0;
              w_state_d = StIgnore;
            end
          end
        end
        StAddrAck: begin
          if (r_rw) begin
            w_load_req = w_scl_fall | r_stretch;
          end else if (w_scl_fall) begin
            w_sda_oe_d = 1'b0;
            w_cnt_d    = '0;
            w_state_d  = StRx;
          end
        end
        StRxAck: begin
          if (w_scl_fall) begin
            w_sda_oe_d = 1'b0;
            w_cnt_d    = '0;
            w_state_d  = StRx;
          end
        end
        StTx: begin
          if (w_scl_rise) begin
            w_cnt_d = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == LastBit) begin
              w_sda_oe_d = 1'b0;
              w_state_d  = StTxAck;
            end else begin
              w_sda_oe_d = (r_shift[DATA_WIDTH-2] == LOW);
              w_shift_d  = r_shift << 1;
            end
          end
        end
        StTxAck: begin
          if (w_scl_rise) begin
            w_ack_d = w_sda_level;
          end else if (w_scl_fall || r_stretch) begin
            if (r_ack == NACK) w_state_d = StIgnore;
            else               w_load_req = 1'b1;
          end
        end
        default: ;
      endcase

      // Byte hand-off; without tx_valid the bus is held low until data arrives.
      if (w_load_req) begin
        if (w_tx_ok) begin
          w_shift_d   = tx_data;
          w_tx_req_d  = 1'b1;
          w_sda_oe_d  = (tx_data[DATA_WIDTH-1] == LOW);
          w_cnt_d     = '0;
          w_state_d   = StTx;
          w_stretch_d = 1'b0;
          w_scl_oe_d  = r_stretch;
        end else begin
          w_stretch_d = 1'b1;
          w_scl_oe_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_sda_oe    <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_rw        <= 1'b0;
      r_busy      <= 1'b0;
      r_ack       <= NACK;
      r_stretch   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_shift     <= w_shift_d;
      r_rx_data   <= w_rx_data_d;
      r_sda_oe    <= w_sda_oe_d;
      r_scl_oe    <= w_scl_oe_d;
      r_rw        <= w_rw_d;
      r_busy      <= w_busy_d;
      r_ack       <= w_ack_d;
      r_stretch   <= w_stretch_d;
      r_rx_valid  <= w_rx_valid_d;
      r_tx_req    <= w_tx_req_d;
      r_start_det <= w_start_det_d;
      r_stop_det  <= w_stop_det_d;
    end
  end

`ifdef I2C_TARGET_CLK_STRETCH_EN
  assign scl_oe = r_scl_oe;
`else
  assign scl_oe = 1'b0;
`endif

  logic w_unused;
  assign w_unused = ^{w_scl_level, w_sda_prev, tx_valid, r_scl_oe};

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_req    = r_tx_req;
  assign rw        = r_rw;
  assign busy      = r_busy;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;

endmodule
